// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit between the execute stage and a simple ready-handshake data
// memory. One access at a time: an aligned load or store is launched from IDLE.
// The unit holds the request in BUSY until the memory answers or the BUSY cycle
// counter expires. It then spends one DONE cycle before it accepts more work.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   flush             suppresses an access that has not started yet
//   alu_out           effective byte address
//   rs2_data          store data, right-aligned
//   dm_w_en           nonzero marks a store
//   wb_sel            1 marks a load (ignored when dm_w_en is nonzero)
//   func3             access size / signedness
//   mem_req/we/be/addr/wdata   registered memory request
//   mem_ready, mem_rdata       memory completion and read word
//   stall             holds the upstream pipeline while an access is in flight
//   load_data         formatted load result, held until the next load completes
//   load_valid        one-cycle pulse with each new load_data
//   misalign_err      one-cycle pulse for a rejected misaligned access
//   bus_err           one-cycle pulse when the memory does not answer in time
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    input  logic [3:0]  dm_w_en,
    input  logic        wb_sel,
    input  logic [2:0]  func3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter is compared one step ahead, so 9 bits hold TIMEOUT=255 safely.
    localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [2:0]  func3_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] load_data_q;
    logic        load_valid_q;
    logic        misalign_q;
    logic        bus_err_q;

    logic        is_store;
    logic        is_load;
    logic        access;
    logic [1:0]  off;
    logic        misaligned;
    logic        start;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [8:0]  cnt_d;
    logic        timeout_hit;

    // Picks the addressed byte/half out of the read word and extends it.
    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  format_load = {{24{byte_v[7]}}, byte_v};
            3'b100:  format_load = {24'd0, byte_v};
            3'b001:  format_load = {{16{half_v[15]}}, half_v};
            3'b101:  format_load = {16'd0, half_v};
            default: format_load = word;
        endcase
    endfunction

    // A store wins when both markers are set.
    assign is_store = (dm_w_en != 4'd0);
    assign is_load  = wb_sel & ~is_store;
    assign access   = is_store | is_load;
    assign off      = alu_out[1:0];

    // Halfword when func3[1:0]=01, word when func3[1]=1, otherwise byte.
    assign misaligned = ((func3[1:0] == 2'b01) & off[0]) |
                        (func3[1] & (off != 2'b00));

    assign start = (state_q == S_IDLE) & access & ~misaligned & ~flush;

    assign stall = ((state_q == S_IDLE) & start) | (state_q == S_BUSY);

    // Byte enables and lane-replicated write data for the request being launched.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = 32'd0;
        if (is_store) begin
            case (func3)
                3'b000: begin
                    be_d    = 4'b0001 << off;
                    wdata_d = {4{rs2_data[7:0]}};
                end
                3'b001: begin
                    be_d    = 4'b0011 << off;
                    wdata_d = {2{rs2_data[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = rs2_data;
                end
            endcase
        end
    end

    assign cnt_d       = {1'b0, cnt_q} + 9'd1;
    assign timeout_hit = (cnt_d >= TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            off_q        <= 2'd0;
            func3_q      <= 3'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store;
                        mem_be_q    <= be_d;
                        mem_addr_q  <= {alu_out[31:2], 2'b00};
                        mem_wdata_q <= wdata_d;
                        off_q       <= off;
                        func3_q     <= func3;
                        cnt_q       <= 8'd0;
                        state_q     <= S_BUSY;
                    end else if (access & misaligned & ~flush) begin
                        misalign_q <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            load_data_q  <= format_load(func3_q, off_q, mem_rdata);
                            load_valid_q <= 1'b1;
                        end
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        // Memory never answered: abandon the access, no load result.
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d[7:0];
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_be       = mem_be_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign load_data    = load_data_q;
    assign load_valid   = load_valid_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [3:0]  dm_w_en;
    logic        wb_sel;
    logic [2:0]  func3;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_err;
    logic        bus_err;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .flush(flush), .alu_out(alu_out),
        .rs2_data(rs2_data), .dm_w_en(dm_w_en), .wb_sel(wb_sel), .func3(func3),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit present();
        return (dm_w_en != 0) || (wb_sel == 1'b1);
    endfunction

    function automatic bit aligned();
        return (int'(alu_out[1:0]) % acc_size(func3)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input bit st, input logic [2:0] f3, input int off);
        if (!st) return 4'hF;
        if (f3 == 3'b000) return 4'(1 << off);
        if (f3 == 3'b001) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        if (f3 == 3'b000) r = {4{d[7:0]}};
        else if (f3 == 3'b001) r = {2{d[15:0]}};
        else r = d;
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        longint v;
        if (f3 == 3'b000 || f3 == 3'b100) begin
            v = (longint'(w) >> (8 * off)) & 255;
            if (f3 == 3'b000 && v >= 128) v = v - 256;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
            v = (longint'(w) >> (8 * off)) & 65535;
            if (f3 == 3'b001 && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(w);
        end
        return v[31:0];
    endfunction

    int          m_phase;   // 0 waiting for work, 1 request outstanding, 2 cool-down
    int          m_waited;
    int          m_off;
    logic [2:0]  m_f3;
    bit          m_req, m_we, m_lv, m_mis, m_berr;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_ld;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_phase = 0; m_waited = 0; m_off = 0; m_f3 = 0;
            m_req = 0; m_we = 0; m_lv = 0; m_mis = 0; m_berr = 0;
            m_be = 0; m_addr = 0; m_wdata = 0; m_ld = 0;
        end else begin
            m_lv = 0; m_mis = 0; m_berr = 0;
            if (m_phase == 0) begin
                if (present() && !flush) begin
                    if (aligned()) begin
                        m_we     = (dm_w_en != 0);
                        m_f3     = func3;
                        m_off    = int'(alu_out[1:0]);
                        m_be     = exp_be(m_we, func3, m_off);
                        m_addr   = alu_out & 32'hFFFF_FFFC;
                        m_wdata  = exp_wdata(func3, rs2_data);
                        m_req    = 1;
                        m_waited = 0;
                        m_phase  = 1;
                    end else begin
                        m_mis = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (mem_ready) begin
                    m_req = 0;
                    if (!m_we) begin
                        m_ld = exp_load(m_f3, m_off, mem_rdata);
                        m_lv = 1;
                    end
                    m_phase = 2;
                end else begin
                    m_waited++;
                    if (m_waited >= TO) begin
                        m_req = 0; m_berr = 1; m_phase = 2;
                    end
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_stall", 32'(stall),
                32'((m_phase == 1) || (m_phase == 0 && present() && aligned() && !flush)));
            chk("cyc_req", 32'(mem_req), 32'(m_req));
            chk("cyc_we", 32'(mem_we), 32'(m_we));
            chk("cyc_be", 32'(mem_be), 32'(m_be));
            chk("cyc_addr", mem_addr, m_addr);
            if (m_we) chk("cyc_wdata", mem_wdata, m_wdata);
            chk("cyc_ld", load_data, m_ld);
            chk("cyc_lv", 32'(load_valid), 32'(m_lv));
            chk("cyc_mis", 32'(misalign_err), 32'(m_mis));
            chk("cyc_berr", 32'(bus_err), 32'(m_berr));
        end
    end

    // ---------------- directed stimulus ----------------
    int stall_cnt, lv_cnt, lv_idx, mis_cnt, mis_idx, berr_cnt, berr_idx, req_cnt, unstable;
    logic [31:0] a0, wd0;
    logic [3:0]  be0;
    logic        we0, last_stall, last_req;

    task automatic set_acc(input logic [3:0] wen, input logic ld, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
        dm_w_en = wen; wb_sel = ld; func3 = f3; alu_out = a; rs2_data = d; mem_rdata = rd;
    endtask

    // Runs n cycles from the current cycle (index 0); the access is held for
    // 'hold' cycles, mem_ready rises at cycle ready_at, flush at flush_at.
    task automatic run(input int n, input int hold, input int ready_at, input int flush_at);
        stall_cnt = 0; lv_cnt = 0; lv_idx = -1; mis_cnt = 0; mis_idx = -1;
        berr_cnt = 0; berr_idx = -1; req_cnt = 0; unstable = 0;
        a0 = 0; wd0 = 0; be0 = 0; we0 = 0;
        mem_ready = (ready_at == 0);
        flush     = (flush_at == 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (load_valid) begin lv_cnt++; lv_idx = i; end
            if (misalign_err) begin mis_cnt++; mis_idx = i; end
            if (bus_err) begin berr_cnt++; berr_idx = i; end
            if (mem_req) begin
                if (req_cnt == 0) begin
                    a0 = mem_addr; be0 = mem_be; we0 = mem_we; wd0 = mem_wdata;
                end else if (mem_addr !== a0 || mem_be !== be0) begin
                    unstable++;
                end
                req_cnt++;
            end
            last_stall = stall;
            last_req   = mem_req;
            @(posedge clk); #1;
            if (i + 1 == hold) begin dm_w_en = 4'd0; wb_sel = 1'b0; end
            mem_ready = (i + 1 >= ready_at);
            flush     = (i + 1 >= flush_at);
        end
        mem_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        set_acc(4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cmp_en = 1;

        @(negedge clk);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_stall", 32'(stall), 0);
        @(posedge clk); #1;

        // LB at 0x103, ready already high
        set_acc(4'd0, 1'b1, 3'b000, 32'h103, 32'd0, 32'h80FF_1234);
        run(6, 1, 0, 99);
        chk("lb_addr", a0, 32'h100);
        chk("lb_be", 32'(be0), 32'hF);
        chk("lb_stall_cycles", stall_cnt, 2);
        chk("lb_lv_cycle", lv_idx, 2);
        chk("lb_lv_count", lv_cnt, 1);
        chk("lb_data", load_data, 32'hFFFF_FF80);

        // SH at 0x22
        set_acc(4'b0011, 1'b0, 3'b001, 32'h22, 32'hABCD_5678, 32'h0);
        run(6, 1, 0, 99);
        chk("sh_be", 32'(be0), 32'hC);
        chk("sh_wdata", wd0, 32'h5678_5678);
        chk("sh_we", 32'(we0), 1);
        chk("sh_addr", a0, 32'h20);
        chk("sh_no_lv", lv_cnt, 0);
        chk("sh_ld_hold", load_data, 32'hFFFF_FF80);

        // LW at 0x41: misaligned
        set_acc(4'd0, 1'b1, 3'b010, 32'h41, 32'd0, 32'h0);
        run(4, 1, 0, 99);
        chk("lw_mis_count", mis_cnt, 1);
        chk("lw_mis_cycle", mis_idx, 1);
        chk("lw_mis_noreq", req_cnt, 0);
        chk("lw_mis_stall", stall_cnt, 0);

        // LHU at 0x12, memory slow
        set_acc(4'd0, 1'b1, 3'b101, 32'h12, 32'd0, 32'hBEEF_1234);
        run(8, 1, 4, 99);
        chk("lhu_unstable", unstable, 0);
        chk("lhu_addr", a0, 32'h10);
        chk("lhu_stall_cycles", stall_cnt, 5);
        chk("lhu_lv_cycle", lv_idx, 5);
        chk("lhu_data", load_data, 32'h0000_BEEF);

        // LW at 0x80, memory never answers
        set_acc(4'd0, 1'b1, 3'b010, 32'h80, 32'd0, 32'h0);
        run(8, 1, 99, 99);
        chk("to_busy_cycles", req_cnt, 4);
        chk("to_berr_count", berr_cnt, 1);
        chk("to_berr_cycle", berr_idx, 5);
        chk("to_no_lv", lv_cnt, 0);
        chk("to_req_dropped", 32'(last_req), 0);
        chk("to_stall_idle", 32'(last_stall), 0);
        chk("to_ld_hold", load_data, 32'h0000_BEEF);

        // both markers set: store wins (SB at 0x7)
        set_acc(4'b1111, 1'b1, 3'b000, 32'h7, 32'h1234_56AB, 32'h0);
        run(5, 1, 1, 99);
        chk("sb_we", 32'(we0), 1);
        chk("sb_be", 32'(be0), 32'h8);
        chk("sb_wdata", wd0, 32'hABAB_ABAB);
        chk("sb_no_lv", lv_cnt, 0);

        // extra formats, model-checked each cycle
        set_acc(4'd0, 1'b1, 3'b001, 32'h6, 32'd0, 32'h8001_7FFF);
        run(5, 1, 0, 99);
        chk("lh_neg", load_data, 32'hFFFF_8001);
        set_acc(4'd0, 1'b1, 3'b100, 32'h101, 32'd0, 32'h0000_F100);
        run(5, 1, 0, 99);
        chk("lbu_data", load_data, 32'h0000_00F1);
        set_acc(4'b1111, 1'b0, 3'b010, 32'h44, 32'h1234_5678, 32'h0);
        run(5, 1, 0, 99);
        chk("sw_wdata", wd0, 32'h1234_5678);

        // flush at start: nothing issued, no error
        set_acc(4'd0, 1'b1, 3'b010, 32'h300, 32'd0, 32'h0);
        run(4, 1, 0, 0);
        chk("fl_noreq", req_cnt, 0);
        chk("fl_nostall", stall_cnt, 0);
        chk("fl_noerr", mis_cnt + berr_cnt, 0);
        set_acc(4'd0, 1'b1, 3'b001, 32'h51, 32'd0, 32'h0);
        run(4, 1, 0, 0);
        chk("fl_mis_suppressed", mis_cnt, 0);

        // flush while BUSY does not abort
        set_acc(4'd0, 1'b1, 3'b010, 32'h60, 32'd0, 32'hCAFE_F00D);
        run(6, 1, 2, 1);
        chk("flb_lv_cycle", lv_idx, 3);
        chk("flb_data", load_data, 32'hCAFE_F00D);

        // reset while BUSY
        set_acc(4'd0, 1'b1, 3'b010, 32'h200, 32'd0, 32'h0);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rb_start_stall", 32'(stall), 1);
        @(posedge clk); #1;
        set_acc(4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rb_busy_req", 32'(mem_req), 1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rb_req", 32'(mem_req), 0);
        chk("rb_we_be", {31'd0, mem_we} | 32'(mem_be), 0);
        chk("rb_addr_wdata", mem_addr | mem_wdata, 0);
        chk("rb_ld", load_data, 0);
        chk("rb_pulses", 32'({load_valid, misalign_err, bus_err}), 0);
        chk("rb_stall", 32'(stall), 0);
        @(posedge clk); #1;

        // unit usable again after reset
        set_acc(4'd0, 1'b1, 3'b010, 32'h204, 32'd0, 32'h1357_9BDF);
        run(5, 1, 0, 99);
        chk("post_rst_lv", lv_idx, 2);
        chk("post_rst_data", load_data, 32'h1357_9BDF);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
